priority_encoder32to5: RTL

PRIORITY_ENCODER32TO5 -- requirements
Module: priority_encoder32to5

---
 rtl/priority_encoder32to5.sv | 107 ++++++++++
 1 files changed

// File: rtl/priority_encoder32to5.sv
// priority_encoder32to5
// Sticky 32-bit request capture feeding a one-entry output slot that
// holds the binary index of the selected pending request.
// Selection policy is fixed priority (index 0 highest) by default;
// defining PRIORITY_ENCODER_ROUND_ROBIN_EN switches to a round-robin
// search starting one past the last granted index.
// Selection looks only at the registered pending set, so there is no
// combinational path from req to the outputs.
module priority_encoder32to5 (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] req,
  input  logic        clear_all,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [4:0]  out_index,
  output logic [31:0] pending,
  output logic [5:0]  pending_count
);

  logic        slot_free;
  logic        load;
  logic        sel_found;
  logic [4:0]  sel_index;
  logic [31:0] grant_mask;
  logic [31:0] pending_next;
  logic [5:0]  count_next;

`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
  logic [4:0] rr_ptr;
  logic [4:0] cand;

  // Round-robin pick: first pending bit at or above rr_ptr, wrapping 31->0
  always_comb begin
    sel_found = 1'b0;
    sel_index = '0;
    cand      = '0;
    for (int unsigned k = 0; k < 32; k++) begin
      cand = rr_ptr + 5'(k);
      if (!sel_found && pending[cand]) begin
        sel_found = 1'b1;
        sel_index = cand;
      end
    end
  end

  // Pointer advances to one past the index loaded into the slot
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (load) begin
      rr_ptr <= sel_index + 5'd1;
    end
  end
`else
  // Fixed-priority pick: lowest-numbered pending bit wins
  always_comb begin
    sel_found = 1'b0;
    sel_index = '0;
    for (int unsigned k = 0; k < 32; k++) begin
      if (!sel_found && pending[k]) begin
        sel_found = 1'b1;
        sel_index = 5'(k);
      end
    end
  end
`endif

  // Slot handshake and next-state pending set
  always_comb begin
    slot_free  = !out_valid || out_ready;
    load       = slot_free && sel_found && !clear_all;
    grant_mask = load ? (32'd1 << sel_index) : '0;
    // A new request on the granted bit re-arms it rather than merging
    pending_next = clear_all ? '0 : ((pending & ~grant_mask) | req);
  end

  // Population count of the next-state pending set
  always_comb begin
    count_next = '0;
    for (int unsigned k = 0; k < 32; k++) begin
      count_next = count_next + 6'(pending_next[k]);
    end
  end

  // State registers: pending set, its count, and the output slot
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending       <= '0;
      pending_count <= '0;
      out_valid     <= 1'b0;
      out_index     <= '0;
    end else begin
      pending       <= pending_next;
      pending_count <= count_next;
      if (clear_all) begin
        out_valid <= 1'b0;
      end else if (slot_free) begin
        out_valid <= sel_found;
        if (sel_found) begin
          out_index <= sel_index;
        end
      end
    end
  end

endmodule
